// File: rtl/tgl_hs_rx_pkg.sv
// Shared types and defaults for the toggle-handshake receiver.
// Holds the FSM state encoding, default widths and the event counter helper.
package tgl_hs_rx_pkg;

    localparam int DW_DEF          = 8;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int EVT_CNT_W       = 16;

    localparam logic [EVT_CNT_W-1:0] EVT_ONE = EVT_CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Free-running wrap: FFFF rolls over to 0 with no flag.
    function automatic logic [EVT_CNT_W-1:0] evt_next(input logic [EVT_CNT_W-1:0] cnt);
        return cnt + EVT_ONE;
    endfunction

endpackage

// File: rtl/tgl_hs_rx_sync_chain.sv
// Generic single-bit synchronizer, N flops deep, async active-low reset to 0.
// Used for req_tgl here; kept free of receiver specifics so it can be reused.
module sync_chain #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [N-1:0] ff;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ff <= '0;
        end else begin
            ff <= {ff[N-2:0], d};
        end
    end

    assign q = ff[N-1];

endmodule

// File: rtl/tgl_hs_rx.sv
// Receive side of a toggle request/acknowledge data handshake into the clkb domain.
// Captures din on each req_tgl level change and returns ack_tgl once downstream consumes the word.
//
// state | meaning
// IDLE  | waiting for a request edge
// HOLD  | word captured, dout_valid high until dout_ready
// ACK   | one-cycle gap after a transfer, ack_tgl already toggled
module tgl_hs_rx
    import tgl_hs_rx_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                 clkb,
    input  logic                 rstn,
    input  logic                 req_tgl,
    input  logic [DW-1:0]        din,
    output logic [DW-1:0]        dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 ack_tgl,
    output logic                 busy,
    output logic                 err_ovf,
    input  logic                 clr_err,
    output logic [EVT_CNT_W-1:0] evt_cnt
);

    logic   req_sync;
    logic   req_hist;
    logic   req_edge;
    logic   req_edge_r;
    state_t state_q;
    state_t state_d;
    logic   cap_en;
    logic   xfer;
    logic   err_set;

    sync_chain #(
        .N (SYNC_STAGES)
    ) u_req_sync (
        .clk  (clkb),
        .rstn (rstn),
        .d    (req_tgl),
        .q    (req_sync)
    );

    assign req_edge = req_sync ^ req_hist;

    // The edge pulse is registered so the FSM sees it one cycle after detection;
    // this sets the request-to-valid latency at SYNC_STAGES+2 edges.
    always_ff @(posedge clkb or negedge rstn) begin
        if (!rstn) begin
            req_hist   <= 1'b0;
            req_edge_r <= 1'b0;
        end else begin
            req_hist   <= req_sync;
            req_edge_r <= req_edge;
        end
    end

    always_ff @(posedge clkb or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_edge_r) state_d = HOLD;
            HOLD:    if (dout_ready) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Requests outside IDLE are protocol violations: flagged, never captured.
    always_comb begin
        cap_en  = (state_q == IDLE) && req_edge_r;
        xfer    = (state_q == HOLD) && dout_ready;
        err_set = (state_q != IDLE) && req_edge_r;
        busy    = (state_q != IDLE);
    end

    always_ff @(posedge clkb or negedge rstn) begin
        if (!rstn) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            ack_tgl    <= 1'b0;
        end else begin
            if (cap_en) begin
                dout       <= din;
                dout_valid <= 1'b1;
            end else if (xfer) begin
                dout_valid <= 1'b0;
            end
            if (xfer) begin
                ack_tgl <= ~ack_tgl;
            end
        end
    end

    always_ff @(posedge clkb or negedge rstn) begin
        if (!rstn) begin
            evt_cnt <= '0;
        end else if (xfer) begin
            evt_cnt <= evt_next(evt_cnt);
        end
    end

    // A set in the same cycle as a clear wins.
    always_ff @(posedge clkb or negedge rstn) begin
        if (!rstn) begin
            err_ovf <= 1'b0;
        end else if (err_set) begin
            err_ovf <= 1'b1;
        end else if (clr_err) begin
            err_ovf <= 1'b0;
        end
    end

endmodule
